// File: rtl/pixel_stream_if.sv
// Frame-buffer read port between pixel_stream (master) and a synchronous BRAM (slave).
// Handshake: fb_re qualifies fb_addr in the same cycle; fb_rdata is valid exactly one
// cycle after fb_re was high. There is no valid/ready pair because the BRAM never stalls.
interface pixel_stream_if #(
  parameter int FB_AW = 15,
  parameter int IDX_W = 4
);
  logic             fb_re;
  logic [FB_AW-1:0] fb_addr;
  logic [IDX_W-1:0] fb_rdata;

  modport master (output fb_re, output fb_addr, input fb_rdata);
  modport slave  (input fb_re, input fb_addr, output fb_rdata);
endinterface

// File: rtl/pixel_stream.sv
// Frame buffer (160x120, 4x4 replicated) -> 16-entry palette -> 12-bit RGB, with syncs
// delayed to match the 2-cycle pipeline. Optional colour-bar source: PIXEL_STREAM_TESTPAT_EN.
module pixel_stream #(
  parameter int FB_AW = 15,
  parameter int IDX_W = 4
) (
  input  logic        vgaclk,
  input  logic        reset,
  input  logic [9:0]  vgaX,
  input  logic [9:0]  vgaY,
  input  logic        hsync,
  input  logic        vsync,
  pixel_stream_if.master fb,
  input  logic        pal_we,
  input  logic [3:0]  pal_idx,
  input  logic [11:0] pal_data,
  input  logic        test_en,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [11:0] rgb,
  output logic        frame_start
);

  // Stage 0: region test and cell address for the coordinate presented this cycle
  logic             active0;
  logic             fetch0;
  logic             tp0;
  logic [FB_AW-1:0] xq;
  logic [FB_AW-1:0] yq;
  logic [FB_AW-1:0] addr0;
  logic [FB_AW-1:0] addr_last;

  assign active0 = (vgaX < 10'd640) && (vgaY < 10'd480);
  assign xq      = FB_AW'(vgaX[9:2]);
  assign yq      = FB_AW'(vgaY[9:2]);
  assign addr0   = (yq << 7) + (yq << 5) + xq;

`ifdef PIXEL_STREAM_TESTPAT_EN
  assign tp0 = test_en;
`else
  logic unused_test_en;
  assign tp0            = 1'b0;
  assign unused_test_en = test_en;
`endif

  // Reset gates the read strobe so the BRAM sees no request while the pipe is cleared
  assign fetch0     = reset && active0 && (vgaX[1:0] == 2'b00) && !tp0;
  assign fb.fb_re   = fetch0;
  assign fb.fb_addr = fetch0 ? addr0 : addr_last;

  // Stage 1/2 registers
  logic             re_d;
  logic             act_d;
  logic             hs_d;
  logic             vs_d;
  logic             fs_d;
  logic [IDX_W-1:0] hold;
  logic [IDX_W-1:0] idx;
  logic [11:0]      palette [16];
`ifdef PIXEL_STREAM_TESTPAT_EN
  logic             tp_d;
  logic [IDX_W-1:0] bar_d;
`endif

  always_comb begin
    idx = re_d ? fb.fb_rdata : hold;
`ifdef PIXEL_STREAM_TESTPAT_EN
    if (tp_d) idx = bar_d;
`endif
  end

  always_ff @(posedge vgaclk or negedge reset) begin
    if (!reset) begin
      addr_last   <= '0;
      re_d        <= 1'b0;
      act_d       <= 1'b0;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      fs_d        <= 1'b0;
      hold        <= '0;
      rgb         <= 12'h000;
      hsync_o     <= 1'b1;
      vsync_o     <= 1'b1;
      frame_start <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        palette[i] <= {i[3:0], i[3:0], i[3:0]};
      end
`ifdef PIXEL_STREAM_TESTPAT_EN
      tp_d  <= 1'b0;
      bar_d <= '0;
`endif
    end else begin
      addr_last <= fb.fb_addr;
      re_d      <= fetch0;
      act_d     <= active0;
      hs_d      <= hsync;
      vs_d      <= vsync;
      fs_d      <= (vgaX == 10'd0) && (vgaY == 10'd0);
`ifdef PIXEL_STREAM_TESTPAT_EN
      tp_d  <= test_en;
      bar_d <= IDX_W'(vgaX[9:6]);
`endif
      // Columns 1..3 of a cell reuse the index fetched at column 0
      hold        <= idx;
      // Palette read and write share this edge: the read sees the old entry
      rgb         <= act_d ? palette[idx] : 12'h000;
      hsync_o     <= hs_d;
      vsync_o     <= vs_d;
      frame_start <= fs_d;
      if (pal_we) palette[pal_idx] <= pal_data;
    end
  end

endmodule
